// File: rtl/msgpass_rd_sched.sv
// rtl/msgpass_rd_sched.sv - read scheduler for message-pass buffer port A
//
// Issues a programmed run of sequential read addresses to the message-pass
// buffer, stalls while memShare reports a data-routing conflict, holds the
// memShare busy flag through the pipeline drain and pulses done on completion.
//
// Optional feature macro: MSGPASS_RD_SCHED_STALLCNT_EN
//   defined   -> stall_cnt_o port and saturating stall counter are built
//   undefined -> no stall_cnt_o port, no counter logic
//
// Ports:
//   sys_clk      system clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      start request (sampled in IDLE only)
//   abort_i      cancel current run (wins over start_i)
//   base_addr_i  first read address, latched with start_i
//   len_i        number of reads, latched with start_i (0 = empty run)
//   is_drc_i     memShare conflict flags, any bit set stalls the issue
//   raddr_o      registered buffer read address
//   rvalid_o     raddr_o is issued this cycle
//   busy_o       memShare busy flag (READ and DRAIN)
//   done_o       one-cycle completion pulse
//   stall_cnt_o  conflict-stalled READ cycles of last/current run (macro only)

module msgpass_rd_sched #(
    parameter int ADDR_W       = 4,
    parameter int DRC_NUM      = 1,
    parameter int DRAIN_CYCLES = 3,
    parameter int STALL_CNT_W  = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [ADDR_W:0]      len_i,
    input  logic [DRC_NUM-1:0]   is_drc_i,
    output logic [ADDR_W-1:0]    raddr_o,
    output logic                 rvalid_o,
    output logic                 busy_o,
    output logic                 done_o
`ifdef MSGPASS_RD_SCHED_STALLCNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                drc;
    logic                accept;

    assign drc    = |is_drc_i;
    // Abort in IDLE blocks a same-cycle start.
    assign accept = (state_q == ST_IDLE) && start_i && !abort_i;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        drain_d  = drain_q;
        rvalid_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d = len_i;
                    cnt_d = '0;
                    if (len_i != '0) begin
                        state_d = ST_READ;
                        raddr_d = base_addr_i;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                busy_o   = 1'b1;
                rvalid_o = !drc;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (!drc) begin
                    cnt_d   = cnt_q + 1'b1;
                    raddr_d = raddr_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                // An abort landing on the DONE cycle suppresses the pulse.
                done_o  = !abort_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign raddr_o = raddr_q;

`ifdef MSGPASS_RD_SCHED_STALLCNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if ((state_q == ST_READ) && drc && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_msgpass_rd_sched.sv
// tb/tb_msgpass_rd_sched.sv - self-checking bench for msgpass_rd_sched

module tb_msgpass_rd_sched;

    localparam int DRAIN = 3;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [3:0]  base_addr_i = '0;
    logic [4:0]  len_i = '0;
    logic [0:0]  is_drc_i = '0;
    logic [3:0]  raddr_o;
    logic        rvalid_o;
    logic        busy_o;
    logic        done_o;
`ifdef MSGPASS_RD_SCHED_STALLCNT_EN
    logic [7:0]  stall_cnt_o;
`endif

    msgpass_rd_sched #(
        .ADDR_W(4), .DRC_NUM(1), .DRAIN_CYCLES(DRAIN), .STALL_CNT_W(8)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .is_drc_i    (is_drc_i),
        .raddr_o     (raddr_o),
        .rvalid_o    (rvalid_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef MSGPASS_RD_SCHED_STALLCNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: reads still owed, drain cycles still owed, pending done.
    int m_left  = 0;
    int m_drain = 0;
    int m_donep = 0;
    int m_addr  = 0;
    int m_stall = 0;

    // Observation log for directed scenarios.
    int obs_busy = 0;
    int obs_done = 0;
    int done_at  = -1;
    int cyc      = 0;
    int obs_issue[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_drain = 0; m_donep = 0; m_addr = 0; m_stall = 0;
    endtask

    task automatic clear_obs();
        obs_busy = 0; obs_done = 0; done_at = -1; cyc = 0;
        obs_issue.delete();
    endtask

    task automatic model_step(input bit st, input bit ab, input int b, input int l, input bit drc);
        bit reading, draining;
        reading  = (m_left > 0);
        draining = (m_left == 0) && (m_drain > 0);
        if (reading && drc && m_stall < 255) m_stall++;
        if (ab) begin
            m_left = 0; m_drain = 0; m_donep = 0;
        end else if (m_donep != 0) begin
            m_donep = 0;
        end else if (reading) begin
            if (!drc) begin
                m_addr = (m_addr + 1) % 16;
                m_left--;
                if (m_left == 0) m_drain = DRAIN;
            end
        end else if (draining) begin
            m_drain--;
            if (m_drain == 0) m_donep = 1;
        end else if (st) begin
            m_stall = 0;
            if (l == 0) m_donep = 1;
            else begin
                m_left = l;
                m_addr = b;
            end
        end
    endtask

    task automatic step(input bit st, input bit ab, input int b, input int l, input bit drc);
        bit e_busy, e_rv, e_done;
        @(negedge sys_clk);
        start_i = st; abort_i = ab; base_addr_i = 4'(b); len_i = 5'(l); is_drc_i = drc;
        #1;
        e_busy = (m_left > 0) || (m_drain > 0);
        e_rv   = (m_left > 0) && !drc;
        e_done = (m_donep != 0) && !ab;
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("rvalid", 32'(rvalid_o), 32'(e_rv));
        chk("done", 32'(done_o), 32'(e_done));
        if (e_rv) chk("raddr", 32'(raddr_o), 32'(m_addr));
`ifdef MSGPASS_RD_SCHED_STALLCNT_EN
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
`endif
        if (busy_o) obs_busy++;
        if (done_o) begin obs_done++; done_at = cyc; end
        if (rvalid_o) obs_issue.push_back(int'(raddr_o));
        cyc++;
        model_step(st, ab, b, l, drc);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_rvalid", 32'(rvalid_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_raddr", 32'(raddr_o), 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        model_reset();
        idle_cycles(2);

        // 1: base 0, len 3, no conflicts
        clear_obs();
        step(1, 0, 0, 3, 0);
        idle_cycles(9);
        chk("t1_busy_cycles", 32'(obs_busy), 6);
        chk("t1_done_cycle", 32'(done_at), 7);
        chk("t1_issues", 32'(obs_issue.size()), 3);

        // 2: conflict for two cycles while raddr=1
        clear_obs();
        step(1, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle_cycles(8);
        chk("t2_busy_cycles", 32'(obs_busy), 8);
        chk("t2_done_cycle", 32'(done_at), 9);
        chk("t2_issues", 32'(obs_issue.size()), 3);
        if (obs_issue.size() == 3) chk("t2_issue2", 32'(obs_issue[2]), 2);

        // 3: address wrap
        clear_obs();
        step(1, 0, 14, 4, 0);
        idle_cycles(10);
        chk("t3_issues", 32'(obs_issue.size()), 4);
        if (obs_issue.size() == 4) begin
            chk("t3_a0", 32'(obs_issue[0]), 14);
            chk("t3_a1", 32'(obs_issue[1]), 15);
            chk("t3_a2", 32'(obs_issue[2]), 0);
            chk("t3_a3", 32'(obs_issue[3]), 1);
        end
        chk("t3_done_cnt", 32'(obs_done), 1);

        // 4: empty run
        clear_obs();
        step(1, 0, 5, 0, 0);
        idle_cycles(4);
        chk("t4_busy_cycles", 32'(obs_busy), 0);
        chk("t4_issues", 32'(obs_issue.size()), 0);
        chk("t4_done_cycle", 32'(done_at), 1);

        // 5: abort at 2nd READ cycle, then a new run with an ignored start
        clear_obs();
        step(1, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t5_busy_after_abort", 32'(busy_o), 0);
        idle_cycles(6);
        chk("t5_no_done", 32'(obs_done), 0);
        clear_obs();
        step(1, 0, 3, 1, 0);
        step(1, 0, 9, 7, 0);
        step(1, 0, 9, 7, 0);
        idle_cycles(6);
        chk("t5_issues", 32'(obs_issue.size()), 1);
        if (obs_issue.size() == 1) chk("t5_a0", 32'(obs_issue[0]), 3);
        chk("t5_done_cnt", 32'(obs_done), 1);

        // abort together with start in IDLE
        clear_obs();
        step(1, 1, 2, 4, 0);
        idle_cycles(4);
        chk("abort_start_busy", 32'(obs_busy), 0);
        chk("abort_start_done", 32'(obs_done), 0);

        // 6: async reset during DRAIN
        clear_obs();
        step(1, 0, 0, 2, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t6_in_drain", 32'(busy_o), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy_o), 0);
        chk("t6_rst_done", 32'(done_o), 0);
        chk("t6_rst_rvalid", 32'(rvalid_o), 0);
        chk("t6_rst_raddr", 32'(raddr_o), 0);
`ifdef MSGPASS_RD_SCHED_STALLCNT_EN
        chk("t6_rst_stall", 32'(stall_cnt_o), 0);
`endif
        model_reset();
        @(negedge sys_clk);
        rst = 1'b0;
        clear_obs();
        step(1, 0, 0, 2, 0);
        idle_cycles(8);
        chk("t6_issues", 32'(obs_issue.size()), 2);
        chk("t6_done_cnt", 32'(obs_done), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 16)),
                 ($urandom_range(0, 3) == 0));
        end
        idle_cycles(24);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
